// File: rtl/key_led_sequencer.sv
// Key-to-LED sequencer: synchronised, debounced keys pick one of four LED pattern modes and run/pause.
// Optional KEY_LED_STATUS_EN exposes {run, mode} on the status port.
module key_led_sequencer #(
  parameter int N_LEDS          = 10,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_DIV        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        key,
  output logic [N_LEDS-1:0] led
`ifdef KEY_LED_STATUS_EN
  ,
  output logic [2:0]        status
`endif
);

  // state    | meaning
  // COUNT    | led counts up in binary on each tick
  // ROT_L    | led rotates left on each tick
  // ROT_R    | led rotates right on each tick
  // PINGPONG | single bit bounces between LSB and MSB
  typedef enum logic [1:0] {
    COUNT    = 2'd0,
    ROT_L    = 2'd1,
    ROT_R    = 2'd2,
    PINGPONG = 2'd3
  } mode_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [N_LEDS-1:0] LED_ONE = N_LEDS'(1);
  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  logic [1:0]         sync1, sync2, deb, deb_d;
  logic [1:0][CW-1:0] cnt;
  logic [1:0]         press;

  mode_t             mode_q, mode_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              dir_q, dir_d;
  logic              run_q, run_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          // this edge is the DEBOUNCE_CYCLES-th disagreeing cycle
          cnt[i] <= '0;
          deb[i] <= ~deb[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press = deb & ~deb_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= COUNT;
      led_q   <= LED_ONE;
      dir_q   <= LEFT;
      run_q   <= 1'b0;
      presc_q <= '0;
    end else begin
      mode_q  <= mode_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      run_q   <= run_d;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (press[0]) begin
      case (mode_q)
        COUNT:    mode_d = ROT_L;
        ROT_L:    mode_d = ROT_R;
        ROT_R:    mode_d = PINGPONG;
        default:  mode_d = COUNT;
      endcase
    end
  end

  assign tick = run_q && (presc_q == PW'(STEP_DIV - 1));

  always_comb begin
    led_d   = led_q;
    dir_d   = dir_q;
    presc_d = presc_q;
    run_d   = press[1] ? ~run_q : run_q;
    if (press[0]) begin
      led_d   = (mode_d == COUNT) ? '0 : LED_ONE;
      dir_d   = LEFT;
      presc_d = '0;
    end else if (run_q) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        case (mode_q)
          COUNT: led_d = led_q + LED_ONE;
          ROT_L: led_d = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
          ROT_R: led_d = {led_q[0], led_q[N_LEDS-1:1]};
          default: begin
            // bounce turns around on the same tick it hits an end
            if (dir_q == LEFT) begin
              if (led_q[N_LEDS-1]) begin
                dir_d = RIGHT;
                led_d = led_q >> 1;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                dir_d = LEFT;
                led_d = led_q << 1;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
        endcase
      end
    end
  end

  assign led = led_q;

`ifdef KEY_LED_STATUS_EN
  assign status = {run_q, mode_q};
`endif

endmodule

// File: tb/tb_key_led_sequencer.sv
// Directed bench for key_led_sequencer (N_LEDS=4, DEBOUNCE_CYCLES=2, STEP_DIV=3).
// Status checks are compiled in only when KEY_LED_STATUS_EN is defined.
module tb_key_led_sequencer;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   key = 2'b00;
  logic [N-1:0] led;
`ifdef KEY_LED_STATUS_EN
  logic [2:0]   status;
`endif

  int checks = 0;
  int errors = 0;

  key_led_sequencer #(
    .N_LEDS(N),
    .DEBOUNCE_CYCLES(2),
    .STEP_DIV(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .led(led)
`ifdef KEY_LED_STATUS_EN
    ,
    .status(status)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic [2:0] exp);
`ifdef KEY_LED_STATUS_EN
    chk(tag, {5'b0, status}, {5'b0, exp});
`endif
  endtask

  task automatic wn(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] pp [7];

  initial begin
    pp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    wn(2);
    chk("reset_led", {4'b0, led}, 8'h01);
    chk_status("reset_status", 3'b000);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      wn(10);
      chk("idle_led", {4'b0, led}, 8'h01);
    end

    key[1] = 1'b1;
    wn(5);
    key[1] = 1'b0;
    chk("run_start_led", {4'b0, led}, 8'h01);
    chk_status("run_start_status", 3'b100);

    // COUNT ticks every 3 cycles; a 1-cycle key[0] glitch is injected mid-sequence
    for (int k = 1; k <= 16; k++) begin
      if (k == 4) begin
        key[0] = 1'b1;
        wn(1);
        key[0] = 1'b0;
        wn(2);
      end else begin
        wn(3);
      end
      chk("count_led", 8'((1 + k) % 16), {4'b0, led});
    end

    key[0] = 1'b1;
    wn(3);
    chk("count_tick_pre_adv", {4'b0, led}, 8'h02);
    wn(2);
    key[0] = 1'b0;
    chk("rotl_load", {4'b0, led}, 8'h01);
    chk_status("rotl_status", 3'b101);
    wn(3); chk("rotl_1", {4'b0, led}, 8'h02);
    wn(3); chk("rotl_2", {4'b0, led}, 8'h04);
    wn(3); chk("rotl_3", {4'b0, led}, 8'h08);
    wn(3); chk("rotl_wrap", {4'b0, led}, 8'h01);

    key[0] = 1'b1;
    wn(3);
    chk("rotl_tick_pre_adv", {4'b0, led}, 8'h02);
    wn(2);
    key[0] = 1'b0;
    chk("rotr_load", {4'b0, led}, 8'h01);
    chk_status("rotr_status", 3'b110);
    wn(3); chk("rotr_1", {4'b0, led}, 8'h08);
    wn(3); chk("rotr_2", {4'b0, led}, 8'h04);

    key[0] = 1'b1;
    wn(3);
    chk("rotr_tick_pre_adv", {4'b0, led}, 8'h02);
    wn(2);
    key[0] = 1'b0;
    chk("pp_load", {4'b0, led}, 8'h01);
    chk_status("pp_status", 3'b111);
    for (int i = 0; i < 7; i++) begin
      wn(3);
      chk("pp_step", {4'b0, led}, {4'b0, pp[i]});
    end

    key[0] = 1'b1;
    wn(3);
    chk("pp_tick_pre_adv", {4'b0, led}, 8'h04);
    wn(2);
    key[0] = 1'b0;
    chk("count_load", {4'b0, led}, 8'h00);
    chk_status("count_status", 3'b100);
    wn(3);
    chk("count_after_load", {4'b0, led}, 8'h01);

    wn(1);
    key = 2'b11;
    wn(2);
    chk("both_pre", {4'b0, led}, 8'h02);
    wn(3);
    key = 2'b00;
    chk("both_load", {4'b0, led}, 8'h01);
    chk_status("both_status", 3'b001);
    for (int i = 0; i < 4; i++) begin
      wn(5);
      chk("frozen_led", {4'b0, led}, 8'h01);
    end

    key[1] = 1'b1;
    wn(5);
    key[1] = 1'b0;
    chk("resume_led", {4'b0, led}, 8'h01);
    wn(3); chk("resume_rotl_1", {4'b0, led}, 8'h02);
    wn(3); chk("resume_rotl_2", {4'b0, led}, 8'h04);

    wn(1);
    #2;
    rst = 1'b1;
    key[1] = 1'b1;
    #1;
    chk("rst_async_led", {4'b0, led}, 8'h01);
    chk_status("rst_async_status", 3'b000);
    wn(2);
    rst = 1'b0;
    chk("rst_release_led", {4'b0, led}, 8'h01);
    wn(5);
    chk("held_key_led", {4'b0, led}, 8'h01);
    chk_status("held_key_status", 3'b100);
    wn(3); chk("held_key_tick1", {4'b0, led}, 8'h02);
    wn(3); chk("held_key_tick2", {4'b0, led}, 8'h03);
    key[1] = 1'b0;
    wn(6); chk("held_key_tick4", {4'b0, led}, 8'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
